// File: rtl/pc_seq_if.sv
// Fetch-stage control bundle between the hazard/redirect sources and the PC sequencer.
// The master drives requests; the slave (sequencer) drives the fetch address and status.
interface pc_seq_if #(
   parameter int WIDTH = 32
);
   logic             stall;
   logic             exc_req;
   logic             jmp;
   logic [WIDTH-1:0] jmp_target;
   logic             br_taken;
   logic [WIDTH-1:0] br_target;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_plus_inc;
   logic             fetch_valid;
   logic             redirect_pending;
   logic             misaligned;

   modport master (
      output stall, exc_req, jmp, jmp_target, br_taken, br_target,
      input  pc, pc_plus_inc, fetch_valid, redirect_pending, misaligned
   );

   modport slave (
      input  stall, exc_req, jmp, jmp_target, br_taken, br_target,
      output pc, pc_plus_inc, fetch_valid, redirect_pending, misaligned
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: boot hold-off, prioritised
// redirects and a one-entry buffer that keeps a redirect raised during a stall.
module pc_sequencer #(
   parameter int                  WIDTH        = 32,
   parameter logic [WIDTH-1:0]    RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0]    EXC_VECTOR   = WIDTH'(32'h80),
   parameter int                  INC          = 4,
   parameter int                  ALIGN_BITS   = 2,
   parameter int                  BOOT_CYCLES  = 2
) (
   input  logic     clk,
   input  logic     reset,
   pc_seq_if.slave  bus
);
   localparam int               CNT_W      = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
   localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
   localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam state_t RESET_STATE = (BOOT_CYCLES == 0) ? RUN : BOOT;

   state_t           state_r,   state_nxt;
   logic [CNT_W-1:0] cnt_r,     cnt_nxt;
   logic [WIDTH-1:0] pc_r,      pc_nxt;
   logic [WIDTH-1:0] pend_r,    pend_nxt;
   logic             pend_v_r,  pend_v_nxt;

   // State, counter, PC and pending-redirect registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= RESET_STATE;
         cnt_r    <= CNT_W'(BOOT_CYCLES);
         pc_r     <= RESET_VECTOR;
         pend_r   <= '0;
         pend_v_r <= 1'b0;
      end else begin
         state_r  <= state_nxt;
         cnt_r    <= cnt_nxt;
         pc_r     <= pc_nxt;
         pend_r   <= pend_nxt;
         pend_v_r <= pend_v_nxt;
      end
   end

   // Next-state and redirect priority: exception, stall capture, jump, branch, buffered, sequential.
   always_comb begin
      state_nxt  = state_r;
      cnt_nxt    = cnt_r;
      pc_nxt     = pc_r;
      pend_nxt   = pend_r;
      pend_v_nxt = pend_v_r;
      case (state_r)
         BOOT: begin
            if (cnt_r <= CNT_W'(1)) begin
               state_nxt = RUN;
            end else begin
               cnt_nxt = cnt_r - CNT_W'(1);
            end
         end
         RUN: begin
            if (bus.exc_req) begin
               pc_nxt     = EXC_VECTOR;
               pend_nxt   = '0;
               pend_v_nxt = 1'b0;
            end else if (bus.stall) begin
               // A newer request while stalled replaces whatever is buffered.
               if (bus.jmp) begin
                  pend_nxt   = bus.jmp_target;
                  pend_v_nxt = 1'b1;
               end else if (bus.br_taken) begin
                  pend_nxt   = bus.br_target;
                  pend_v_nxt = 1'b1;
               end else begin
                  pend_nxt   = pend_r;
               end
            end else if (bus.jmp) begin
               pc_nxt     = bus.jmp_target;
               pend_nxt   = '0;
               pend_v_nxt = 1'b0;
            end else if (bus.br_taken) begin
               pc_nxt     = bus.br_target;
               pend_nxt   = '0;
               pend_v_nxt = 1'b0;
            end else if (pend_v_r) begin
               pc_nxt     = pend_r;
               pend_nxt   = '0;
               pend_v_nxt = 1'b0;
            end else begin
               pc_nxt     = pc_r + INC_W;
            end
         end
         default: begin
            state_nxt  = RUN;
            pc_nxt     = RESET_VECTOR;
            pend_nxt   = '0;
            pend_v_nxt = 1'b0;
         end
      endcase
   end

   assign bus.pc               = pc_r;
   assign bus.pc_plus_inc      = pc_r + INC_W;
   assign bus.fetch_valid      = (state_r == RUN) & ~bus.stall;
   assign bus.redirect_pending = pend_v_r;
   assign bus.misaligned       = |(pc_r & ALIGN_MASK);
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// requests, all compared against a behavioural model of the fetch sequencer.
module tb_pc_sequencer;
   logic clk;
   logic reset;

   pc_seq_if #(.WIDTH(32)) bus ();

   pc_sequencer #(
      .WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h80),
      .INC(4), .ALIGN_BITS(2), .BOOT_CYCLES(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_bad;

   // Reference model state: edges seen since reset, current pc, buffered redirect.
   int          m_edges;
   logic [31:0] m_pc;
   logic        m_pv;
   logic [31:0] m_pend;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check_val({tag, "_pc"},  bus.pc, m_pc);
      check_val({tag, "_inc"}, bus.pc_plus_inc, m_pc + 32'd4);
      check_val({tag, "_fv"},  32'(bus.fetch_valid), 32'((m_edges >= 2) && !bus.stall));
      check_val({tag, "_rp"},  32'(bus.redirect_pending), 32'(m_pv));
      check_val({tag, "_mis"}, 32'(bus.misaligned), 32'((m_pc % 32'd4) != 32'd0));
   endtask

   task automatic model_edge();
      if (m_edges < 2) begin
         m_edges++;
      end else if (bus.exc_req) begin
         m_pc = 32'h80; m_pv = 1'b0;
      end else if (bus.stall) begin
         if (bus.jmp) begin m_pend = bus.jmp_target; m_pv = 1'b1; end
         else if (bus.br_taken) begin m_pend = bus.br_target; m_pv = 1'b1; end
      end else if (bus.jmp) begin
         m_pc = bus.jmp_target; m_pv = 1'b0;
      end else if (bus.br_taken) begin
         m_pc = bus.br_target; m_pv = 1'b0;
      end else if (m_pv) begin
         m_pc = m_pend; m_pv = 1'b0;
      end else begin
         m_pc = m_pc + 32'd4;
      end
   endtask

   // One clock: apply inputs, let the edge happen, update the model, compare.
   task automatic cycle(input logic st, input logic ex, input logic j, input logic [31:0] jt,
                        input logic b, input logic [31:0] bt, input string tag);
      bus.stall = st; bus.exc_req = ex; bus.jmp = j; bus.jmp_target = jt;
      bus.br_taken = b; bus.br_target = bt;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, tag);
   endtask

   // Asynchronous reset pulse placed between edges, checked before any edge.
   task automatic do_reset(input logic keep_stall);
      #2;
      reset = 1'b1;
      m_edges = 0; m_pc = 32'h0; m_pv = 1'b0; m_pend = 32'h0;
      #1;
      check_val("rst_pc", bus.pc, 32'h0);
      check_val("rst_rp", 32'(bus.redirect_pending), 32'd0);
      check_val("rst_fv", 32'(bus.fetch_valid), 32'd0);
      bus.stall = keep_stall;
      #1;
      check_val("rst_fv_nostall", 32'(bus.fetch_valid), 32'd0);
      bus.stall = 1'b0; bus.exc_req = 1'b0; bus.jmp = 1'b0; bus.br_taken = 1'b0;
      @(posedge clk);
      #1;
      check_all("rst_hold");
      #2;
      reset = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      m_edges = 0; m_pc = 32'h0; m_pv = 1'b0; m_pend = 32'h0;
      bus.stall = 1'b0; bus.exc_req = 1'b0; bus.jmp = 1'b0; bus.br_taken = 1'b0;
      bus.jmp_target = 32'h0; bus.br_target = 32'h0;
      reset = 1'b1;
      #12;
      reset = 1'b0;
      #1;

      // T1: boot hold-off ignores requests, then sequential stepping.
      cycle(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, "t1_boot1");
      check_val("t1_fv0", 32'(bus.fetch_valid), 32'd0);
      idle("t1_boot2");
      check_val("t1_pc0", bus.pc, 32'h0);
      check_val("t1_fv1", 32'(bus.fetch_valid), 32'd1);
      idle("t1_s4");
      check_val("t1_pc4", bus.pc, 32'h4);
      idle("t1_s8");
      check_val("t1_pc8", bus.pc, 32'h8);

      // T2: branch captured during a stall lands when the stall drops.
      cycle(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, "t2_set");
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, "t2_cap");
      check_val("t2_hold", bus.pc, 32'h10);
      check_val("t2_rp1", 32'(bus.redirect_pending), 32'd1);
      idle("t2_rel");
      check_val("t2_pc", bus.pc, 32'h100);
      check_val("t2_rp0", 32'(bus.redirect_pending), 32'd0);

      // T3: exception beats stall and jump.
      cycle(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, "t3");
      check_val("t3_pc", bus.pc, 32'h80);
      check_val("t3_rp", 32'(bus.redirect_pending), 32'd0);

      // T4: jump beats branch; a fresh branch beats the buffered target.
      cycle(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h400, "t4_jb");
      check_val("t4_pc", bus.pc, 32'h300);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, "t4_cap");
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500, "t4_new");
      check_val("t4_pc2", bus.pc, 32'h500);
      check_val("t4_rp", 32'(bus.redirect_pending), 32'd0);
      idle("t4_after");
      check_val("t4_seq", bus.pc, 32'h504);

      // T5: wrap-around and misaligned target.
      cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, "t5_top");
      check_val("t5_inc", bus.pc_plus_inc, 32'h0);
      idle("t5_wrap");
      check_val("t5_pc0", bus.pc, 32'h0);
      cycle(1'b0, 1'b0, 1'b1, 32'h202, 1'b0, 32'h0, "t5_mis");
      check_val("t5_pc", bus.pc, 32'h202);
      check_val("t5_misf", 32'(bus.misaligned), 32'd1);

      // T6: reset in the middle of a stall with a buffered redirect.
      cycle(1'b1, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0, "t6_cap");
      check_val("t6_rp", 32'(bus.redirect_pending), 32'd1);
      do_reset(1'b1);
      idle("t6_b1");
      idle("t6_b2");

      // Random traffic, with the occasional asynchronous reset.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] jt;
         logic [31:0] bt;
         jt = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 15) * 4);
         bt = $urandom();
         if ($urandom_range(0, 3) != 0) bt = bt & 32'hFFFF_FFFC;
         if ($urandom_range(0, 99) == 0) begin
            do_reset(1'($urandom_range(0, 1)));
         end else begin
            cycle(1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 6) == 0), jt,
                  1'($urandom_range(0, 4) == 0), bt, "rnd");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
